// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: NBITS shift-add or restoring shift-subtract steps
// on operand magnitudes, with sign correction applied as the result is loaded.
module muldiv_unit #(
   parameter int NBITS  = 32,
   parameter int OPBITS = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [OPBITS-1:0] i_op,
   input  logic [NBITS-1:0]  i_rs,
   input  logic [NBITS-1:0]  i_rt,
   output logic [NBITS-1:0]  o_hi,
   output logic [NBITS-1:0]  o_lo,
   output logic              o_busy,
   output logic              o_done
);

   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic [NBITS-1:0]   operand;
   logic [2*NBITS-1:0] acc;
   logic [2*NBITS-1:0] acc_step;
   logic               last_iter;

   logic               rs_neg, rt_neg;
   logic [NBITS-1:0]   rs_mag, rt_mag;
   logic [NBITS:0]     add_sum, rem_shift, rem_diff;
   logic [2*NBITS-1:0] prod_fix;
   logic [NBITS-1:0]   quot, rem;
   logic [NBITS-1:0]   res_hi, res_lo;

   assign last_iter = (count == CW'(NBITS - 1));

   // operand magnitudes; i_op[0] selects the signed variants
   always_comb begin
      rs_neg = i_op[0] & i_rs[NBITS-1];
      rt_neg = i_op[0] & i_rt[NBITS-1];
      rs_mag = rs_neg ? -i_rs : i_rs;
      rt_mag = rt_neg ? -i_rt : i_rt;
   end

   always_comb begin
      add_sum   = {1'b0, acc[2*NBITS-1:NBITS]} + {1'b0, operand};
      rem_shift = acc[2*NBITS-1:NBITS-1];
      rem_diff  = rem_shift - {1'b0, operand};
      acc_step  = acc;
      if (is_div) begin
         if (!rem_diff[NBITS])
            acc_step = {rem_diff[NBITS-1:0], acc[NBITS-2:0], 1'b1};
         else
            acc_step = {rem_shift[NBITS-1:0], acc[NBITS-2:0], 1'b0};
      end else if (acc[0]) begin
         acc_step = {add_sum, acc[NBITS-1:1]};
      end else begin
         acc_step = {1'b0, acc[2*NBITS-1:1]};
      end
   end

   always_comb begin
      prod_fix = neg_lo ? -acc_step : acc_step;
      quot     = acc_step[NBITS-1:0];
      rem      = acc_step[2*NBITS-1:NBITS];
      res_hi   = prod_fix[2*NBITS-1:NBITS];
      res_lo   = prod_fix[NBITS-1:0];
      if (is_div) begin
         res_hi = neg_hi ? -rem : rem;
         res_lo = neg_lo ? -quot : quot;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (i_start) state_next = CALC;
         CALC:    if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != IDLE);
      o_done = (state == DONE);
   end

   // A zero divisor leaves an all-ones quotient, so its sign flip is suppressed
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count   <= '0;
         is_div  <= 1'b0;
         neg_lo  <= 1'b0;
         neg_hi  <= 1'b0;
         operand <= '0;
         acc     <= '0;
         o_hi    <= '0;
         o_lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  count  <= '0;
                  is_div <= i_op[1];
                  neg_hi <= rs_neg;
                  if (i_op[1]) begin
                     neg_lo  <= (rs_neg ^ rt_neg) & (i_rt != '0);
                     operand <= rt_mag;
                     acc     <= {{NBITS{1'b0}}, rs_mag};
                  end else begin
                     neg_lo  <= rs_neg ^ rt_neg;
                     operand <= rs_mag;
                     acc     <= {{NBITS{1'b0}}, rt_mag};
                  end
               end
            end
            CALC: begin
               acc   <= acc_step;
               count <= count + CW'(1);
               if (last_iter) begin
                  o_hi <= res_hi;
                  o_lo <= res_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table run back to back, plus input
// toggling during CALC and a reset abort in mid-operation.
module tb_muldiv_unit;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_rs, i_rt;
   logic [31:0] o_hi, o_lo;
   logic        o_busy, o_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   muldiv_unit #(.NBITS(32), .OPBITS(2)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_op    (i_op),
      .i_rs    (i_rs),
      .i_rt    (i_rt),
      .o_hi    (o_hi),
      .o_lo    (o_lo),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, output int done_at);
      logic [31:0] prev_hi, prev_lo;
      int          lat;
      int          j;
      bit          busy_ok;
      @(negedge i_clk);
      check({v.name, " idle before start"}, {30'b0, o_busy, o_done}, 32'd0);
      prev_hi = o_hi;
      prev_lo = o_lo;
      i_rst   = 1'b0;
      i_start = 1'b1;
      i_op    = v.op;
      i_rs    = v.rs;
      i_rt    = v.rt;
      @(posedge i_clk);
      #1;
      check({v.name, " busy at start"}, {30'b0, o_busy, o_done}, 32'd2);
      i_start = 1'b0;
      i_op    = ~v.op;
      i_rs    = ~v.rs;
      i_rt    = v.rt + 32'd1;
      lat     = 0;
      j       = 0;
      busy_ok = 1'b1;
      while (lat == 0 && j < 40) begin
         @(negedge i_clk);
         j++;
         if (o_done) lat = j;
         else if (!o_busy) busy_ok = 1'b0;
         if (j == 16) begin
            check({v.name, " hi hold"}, o_hi, prev_hi);
            check({v.name, " lo hold"}, o_lo, prev_lo);
         end
      end
      check({v.name, " latency"}, 32'(lat), 32'd33);
      check({v.name, " busy window"}, {31'b0, busy_ok}, 32'd1);
      check({v.name, " hi"}, o_hi, v.hi);
      check({v.name, " lo"}, o_lo, v.lo);
      done_at = cyc;
      $display("%s: op=%0d rs=%h rt=%h -> hi=%h lo=%h lat=%0d",
               v.name, v.op, v.rs, v.rt, o_hi, o_lo, lat);
   endtask

   initial begin
      int   d, prev_d;
      int   ndone, done_j;
      logic [31:0] got_hi, got_lo;
      vec_t v;

      vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "multu max*2"};
      vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5"};
      vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
      vecs[3]  = '{2'b10, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, "divu 5/0"};
      vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
      vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"};
      vecs[6]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7"};
      vecs[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div 7/-2"};
      vecs[8]  = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div -7/0"};
      vecs[9]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max*max"};
      vecs[10] = '{2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "mult 7*-1"};
      vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, "divu max/16"};
      vecs[12] = '{2'b00, 32'd6,        32'd7,        32'd0,        32'd42,       "multu 6*7"};

      // reset held with start high: outputs must stay cleared
      i_rst   = 1'b1;
      i_start = 1'b1;
      i_op    = 2'b00;
      i_rs    = 32'h1234;
      i_rt    = 32'h5;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset hi", o_hi, 32'd0);
      check("reset lo", o_lo, 32'd0);
      check("reset busy/done", {30'b0, o_busy, o_done}, 32'd0);

      // table, issued back to back; first start coincides with reset release
      prev_d = 0;
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i], d);
         if (i > 0) check({vecs[i].name, " b2b gap"}, 32'(d - prev_d), 32'd34);
         prev_d = d;
      end

      // inputs and start toggled during CALC must not disturb DIVU 100/7
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = 2'b10;
      i_rs    = 32'd100;
      i_rt    = 32'd7;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      ndone   = 0;
      done_j  = 0;
      got_hi  = '0;
      got_lo  = '0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge i_clk);
         if (o_done) begin
            ndone++;
            done_j = j;
            got_hi = o_hi;
            got_lo = o_lo;
         end
         i_start = (j < 33) && (j % 3 == 0);
         i_op    = 2'($urandom);
         i_rs    = $urandom;
         i_rt    = $urandom;
      end
      i_start = 1'b0;
      check("toggle done count", 32'(ndone), 32'd1);
      check("toggle latency", 32'(done_j), 32'd33);
      check("toggle hi", got_hi, 32'd2);
      check("toggle lo", got_lo, 32'd14);
      $display("toggle divu 100/7: hi=%h lo=%h dones=%0d", got_hi, got_lo, ndone);

      // reset pulse 10 cycles into CALC aborts the operation
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = 2'b00;
      i_rs    = 32'hFFFFFFFF;
      i_rt    = 32'hFFFFFFFF;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (10) @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("abort busy/done", {30'b0, o_busy, o_done}, 32'd0);
      check("abort hi", o_hi, 32'd0);
      check("abort lo", o_lo, 32'd0);
      #2;
      i_rst = 1'b0;
      ndone = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge i_clk);
         if (o_done || o_busy) ndone++;
      end
      check("abort no activity", 32'(ndone), 32'd0);
      $display("abort: hi=%h lo=%h", o_hi, o_lo);

      v = vecs[12];
      v.name = "after abort multu 6*7";
      run_op(v, d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter OPBITS, default 2, giving the operation-select width.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_start  input  1  SHALL request a new operation; it is sampled only in IDLE.
REQ-006 i_op  input  OPBITS  SHALL select the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 i_rs  input  NBITS  SHALL carry the multiplicand or dividend.
REQ-008 i_rt  input  NBITS  SHALL carry the multiplier or divisor.
REQ-009 o_hi  output  NBITS  SHALL carry the product high word, or the remainder for divides.
REQ-010 o_lo  output  NBITS  SHALL carry the product low word, or the quotient for divides.
REQ-011 o_busy  output  1  SHALL be high whenever the state is not IDLE; the pipeline uses it to stall MFHI/MFLO and mult/div instructions.
REQ-012 o_done  output  1  SHALL be a one-cycle pulse marking the cycle in which new o_hi/o_lo values are first valid.

Function
REQ-013 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE to CALC SHALL occur when i_start=1 at edge k; i_op, i_rs and i_rt SHALL be captured at edge k, and the iteration counter SHALL be cleared.
REQ-015 Changes on i_op, i_rs or i_rt after edge k SHALL have no effect on the running operation.
REQ-016 CALC SHALL perform exactly one iteration per edge, at edges k+1 through k+NBITS: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 The transition to DONE SHALL occur at edge k+NBITS, and o_hi/o_lo SHALL be loaded with the final result at that same edge.
REQ-018 DONE SHALL last exactly one cycle with o_done=1, and SHALL return to IDLE at edge k+NBITS+1.
REQ-019 Timing summary: o_busy is high from edge k to edge k+NBITS+1, and o_done is high between edges k+NBITS and k+NBITS+1.
REQ-020 i_start SHALL be ignored in CALC and DONE; it SHALL neither restart, queue nor corrupt the operation.
REQ-021 Back-to-back operation: an i_start asserted in the first IDLE cycle after DONE SHALL be accepted.
REQ-022 o_hi/o_lo SHALL hold their previous values in IDLE and CALC, and change only at the DONE entry edge.
REQ-023 MULTU/DIVU SHALL treat operands as unsigned; the 2*NBITS product SHALL be split with {o_hi,o_lo}=rs*rt.
REQ-024 MULT/DIV SHALL operate on magnitudes and apply the sign correction in the final step. The product sign is rs XOR rt. The quotient sign is rs XOR rt. The remainder sign follows rs.
REQ-025 Divide by zero (both DIV and DIVU) SHALL take normal latency, giving o_lo = all ones and o_hi = captured rs.
REQ-026 Signed DIV of most-negative by -1 SHALL give o_lo = most-negative value and o_hi = 0, with no exception and no extra cycles.
REQ-027 Signed MULT of most-negative by most-negative SHALL give the exact 2*NBITS product (0x40000000_00000000 for NBITS=32).

Reset
REQ-028 While i_rst=1, the state SHALL be IDLE, the counter 0, the operand registers 0, o_hi=0, o_lo=0, o_busy=0 and o_done=0, independent of i_clk.
REQ-029 Reset asserted during CALC or DONE SHALL abort the operation immediately; no o_done pulse SHALL follow and o_hi/o_lo SHALL read 0.
REQ-030 The first i_start SHALL be accepted at the first rising edge after i_rst is deasserted.

Verification (NBITS=32)
REQ-031 MULTU rs=0xFFFFFFFF, rt=2, start at edge k -> o_busy high from k; o_done high only between edges k+32 and k+33; o_hi=0x00000001, o_lo=0xFFFFFFFE.
REQ-032 MULT rs=-3 (0xFFFFFFFD), rt=5 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFF1; then DIV rs=-7, rt=2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF.
REQ-033 DIVU rs=5, rt=0 -> o_lo=0xFFFFFFFF, o_hi=0x00000005 after normal 33-cycle busy window; DIV rs=0x80000000, rt=0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
REQ-034 Start DIVU 100/7, then pulse i_start with new operands and toggle inputs during CALC -> result unchanged (o_lo=14, o_hi=2), exactly one o_done pulse.
REQ-035 Reset pulsed 10 cycles into CALC -> o_busy=0, o_hi=o_lo=0 asynchronously, no o_done; a subsequent MULTU 6*7 yields o_lo=42, o_hi=0.
REQ-036 Back-to-back: start asserted in the IDLE cycle immediately after o_done -> accepted; the second result appears exactly 34 cycles after the first o_done.
